// File: rtl/multicycle_alu.sv
// Handshaked multi-cycle ALU: single-cycle logic/arith ops, one-bit-per-cycle
// shifts and an unsigned shift-add multiplier, with registered result and flags.
module multicycle_alu #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [3:0]            opcode,
  input  logic [DATA_WIDTH-1:0] in1,
  input  logic [DATA_WIDTH-1:0] in2,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  busy,
  output logic                  done,
  output logic                  zero,
  output logic                  negative,
  output logic                  carry,
  output logic                  overflow,
  output logic                  shift_flag
);
  localparam int W       = DATA_WIDTH;
  localparam int SHAMT_W = $clog2(DATA_WIDTH);
  localparam int CW      = SHAMT_W + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MUL = CW'(DATA_WIDTH);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_INV = 4'd5;
  localparam logic [3:0] OP_CLR = 4'd6;
  localparam logic [3:0] OP_LSH = 4'd7;
  localparam logic [3:0] OP_RSH = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, MUL = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [W-1:0]    mcand_q, mcand_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            left_q, left_d;
  logic [W-1:0]    out_q, out_d;
  logic            zero_q, zero_d, negative_q, negative_d;
  logic            carry_q, carry_d, overflow_q, overflow_d;
  logic            shift_flag_q, shift_flag_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic            upd_zn_s;

  logic [SHAMT_W-1:0] k_s;
  logic [W:0]         add_s, sub_s, mul_sum_s;
  logic [W-1:0]       shifted_s;
  logic               shout_s;
  logic [2*W-1:0]     mul_next_s;

  assign k_s       = in2[SHAMT_W-1:0];
  assign add_s     = {1'b0, in1} + {1'b0, in2};
  assign sub_s     = {1'b0, in1} - {1'b0, in2};
  assign shifted_s = left_q ? {acc_q[W-2:0], 1'b0} : {1'b0, acc_q[W-1:1]};
  assign shout_s   = left_q ? acc_q[W-1] : acc_q[0];
  // Multiplier sits in the low half and is consumed LSB first while the product grows from the top.
  assign mul_sum_s  = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? mcand_q : {W{1'b0}})};
  assign mul_next_s = {mul_sum_s, acc_q[W-1:1]};

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    mcand_d      = mcand_q;
    cnt_d        = cnt_q;
    left_d       = left_q;
    out_d        = out_q;
    zero_d       = zero_q;
    negative_d   = negative_q;
    carry_d      = carry_q;
    overflow_d   = overflow_q;
    shift_flag_d = shift_flag_q;
    done_d       = 1'b0;
    upd_zn_s     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          done_d   = 1'b1;
          upd_zn_s = 1'b1;
          case (opcode)
            OP_ADD: begin
              out_d      = add_s[W-1:0];
              carry_d    = add_s[W];
              overflow_d = (in1[W-1] == in2[W-1]) && (add_s[W-1] != in1[W-1]);
            end
            OP_SUB: begin
              out_d      = sub_s[W-1:0];
              carry_d    = sub_s[W];
              overflow_d = (in1[W-1] != in2[W-1]) && (sub_s[W-1] != in1[W-1]);
            end
            OP_AND: begin out_d = in1 & in2;     carry_d = 1'b0; overflow_d = 1'b0; end
            OP_OR:  begin out_d = in1 | in2;     carry_d = 1'b0; overflow_d = 1'b0; end
            OP_XOR: begin out_d = in1 ^ in2;     carry_d = 1'b0; overflow_d = 1'b0; end
            OP_INV: begin out_d = ~in1;          carry_d = 1'b0; overflow_d = 1'b0; end
            OP_CLR: begin out_d = {W{1'b0}};     carry_d = 1'b0; overflow_d = 1'b0; end
            OP_LSH, OP_RSH: begin
              if (k_s == {SHAMT_W{1'b0}}) begin
                out_d        = in1;
                shift_flag_d = 1'b0;
                carry_d      = 1'b0;
                overflow_d   = 1'b0;
              end else begin
                done_d  = 1'b0;
                state_d = SHIFT;
                acc_d   = {{W{1'b0}}, in1};
                cnt_d   = {1'b0, k_s};
                left_d  = (opcode == OP_LSH);
              end
            end
            OP_MUL: begin
              done_d  = 1'b0;
              state_d = MUL;
              acc_d   = {{W{1'b0}}, in2};
              mcand_d = in1;
              cnt_d   = CNT_MUL;
            end
            default: upd_zn_s = 1'b0;
          endcase
        end else begin
          done_d = 1'b0;
        end
      end
      SHIFT: begin
        acc_d = {{W{1'b0}}, shifted_s};
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d      = IDLE;
          done_d       = 1'b1;
          upd_zn_s     = 1'b1;
          out_d        = shifted_s;
          shift_flag_d = shout_s;
          carry_d      = 1'b0;
          overflow_d   = 1'b0;
        end else begin
          done_d = 1'b0;
        end
      end
      MUL: begin
        acc_d = mul_next_s;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d    = IDLE;
          done_d     = 1'b1;
          upd_zn_s   = 1'b1;
          out_d      = mul_next_s[W-1:0];
          carry_d    = 1'b0;
          overflow_d = |mul_next_s[2*W-1:W];
        end else begin
          done_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (done_d && upd_zn_s) begin
      zero_d     = (out_d == {W{1'b0}});
      negative_d = out_d[W-1];
    end else begin
      zero_d     = zero_q;
      negative_d = negative_q;
    end
    busy_d = (state_d != IDLE);
  end

  // State, datapath and output registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      acc_q        <= {(2*W){1'b0}};
      mcand_q      <= {W{1'b0}};
      cnt_q        <= {CW{1'b0}};
      left_q       <= 1'b0;
      out_q        <= {W{1'b0}};
      zero_q       <= 1'b0;
      negative_q   <= 1'b0;
      carry_q      <= 1'b0;
      overflow_q   <= 1'b0;
      shift_flag_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      mcand_q      <= mcand_d;
      cnt_q        <= cnt_d;
      left_q       <= left_d;
      out_q        <= out_d;
      zero_q       <= zero_d;
      negative_q   <= negative_d;
      carry_q      <= carry_d;
      overflow_q   <= overflow_d;
      shift_flag_q <= shift_flag_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign out        = out_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign zero       = zero_q;
  assign negative   = negative_q;
  assign carry      = carry_q;
  assign overflow   = overflow_q;
  assign shift_flag = shift_flag_q;
endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu: directed cases plus random ops, checked
// against an arithmetic reference model by a decoupled done-driven monitor.
module tb_multicycle_alu;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic [7:0] in1 = 8'h00, in2 = 8'h00, out;
  logic       busy, done, zero, negative, carry, overflow, shift_flag;

  typedef struct {
    logic [7:0] o;
    logic [4:0] f;      // {zero, negative, carry, overflow, shift_flag}
    int         due;
    int         lat;
    bit         g_on;
    logic [7:0] g_o;
    logic [4:0] g_f;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_x;
  int         total = 0, bad = 0, cyc = 0, next_free = 0, bcnt = 0;
  logic [7:0] m_out = 8'h00;
  logic [4:0] m_f = 5'b00000;
  logic [7:0] last_o = 8'h00;
  logic [4:0] last_f = 5'b00000;
  logic       rst_seen = 1'b0;
  bit         end_req = 1'b0;

  multicycle_alu #(.DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .in1(in1), .in2(in2),
    .out(out), .busy(busy), .done(done), .zero(zero), .negative(negative),
    .carry(carry), .overflow(overflow), .shift_flag(shift_flag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
  end

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference model: updates the architectural result/flags and returns the latency.
  task automatic model(input logic [3:0] op, input logic [7:0] a8, input logic [7:0] b8, output int lat);
    int a, b, k, r, p, sa, sb, s;
    bit c, v, sf, upd;
    a = a8; b = b8; k = b % 8;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    r = m_out; sf = m_f[0]; c = 1'b0; v = 1'b0; upd = 1'b1; lat = 0;
    case (op)
      4'd0: begin r = a + b; c = (r > 255); s = sa + sb; v = (s > 127) || (s < -128); end
      4'd1: begin r = a - b; c = (a < b);   s = sa - sb; v = (s > 127) || (s < -128); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: r = 0;
      4'd7: begin lat = k; r = a << k; sf = (k == 0) ? 1'b0 : 1'((a >> (8 - k)) & 1); end
      4'd8: begin lat = k; r = a >> k; sf = (k == 0) ? 1'b0 : 1'((a >> (k - 1)) & 1); end
      4'd9: begin lat = 8; p = a * b; r = p; v = ((p >> 8) != 0); end
      default: upd = 1'b0;
    endcase
    r = r & 255;
    if (upd) begin
      m_out = 8'(r);
      m_f   = {(r == 0), (r > 127), c, v, sf};
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input bit g_on = 1'b0, input logic [7:0] g_o = 8'h00, input logic [4:0] g_f = 5'b00000);
    exp_t x;
    int   e, lat;
    e = cyc + 1;
    opcode = op; in1 = a; in2 = b; start = 1'b1;
    if (e >= next_free) begin
      model(op, a, b, lat);
      x.o = m_out; x.f = m_f; x.lat = lat; x.due = e + lat;
      x.g_on = g_on; x.g_o = g_o; x.g_f = g_f;
      exp_q.push_back(x);
      next_free = e + lat + 1;
    end
    @(negedge clk);
    start = 1'b0; opcode = 4'($urandom); in1 = 8'($urandom); in2 = 8'($urandom);
  endtask

  task automatic wait_idle();
    while (cyc + 1 < next_free) @(negedge clk);
  endtask

  task automatic do_reset(input bit with_start);
    reset = 1'b1; start = with_start; opcode = 4'd0; in1 = 8'h11; in2 = 8'h22;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    m_out = 8'h00; m_f = 5'b00000; next_free = 0;
    @(negedge clk);
  endtask

  // Monitor: pops one expectation per done pulse, otherwise checks that out/flags hold.
  always @(negedge clk) begin
    if (rst_seen) begin
      check("reset_out", out, 0);
      check("reset_flags", {zero, negative, carry, overflow, shift_flag}, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      exp_q.delete();
      last_o = 8'h00; last_f = 5'b00000; bcnt = 0;
    end else if (done) begin
      check("done_has_request", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        mon_x = exp_q.pop_front();
        check("out", out, mon_x.o);
        check("flags", {zero, negative, carry, overflow, shift_flag}, mon_x.f);
        check("done_cycle", cyc, mon_x.due);
        check("busy_at_done", busy, 0);
        check("busy_cycles", bcnt, mon_x.lat);
        if (mon_x.g_on) begin
          check("golden_out", out, mon_x.g_o);
          check("golden_flags", {zero, negative, carry, overflow, shift_flag}, mon_x.g_f);
        end
        last_o = mon_x.o; last_f = mon_x.f;
      end
      bcnt = 0;
    end else begin
      check("hold", {out, zero, negative, carry, overflow, shift_flag}, {last_o, last_f});
      if (busy) bcnt++;
    end
    if (end_req) begin
      check("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue(4'd0, 8'h7F, 8'h01, 1'b1, 8'h80, 5'b01010);
    wait_idle();
    issue(4'd1, 8'h00, 8'h01, 1'b1, 8'hFF, 5'b01100);
    wait_idle();
    issue(4'd12, 8'h12, 8'h34, 1'b1, 8'hFF, 5'b01100);
    wait_idle();
    issue(4'd8, 8'hB5, 8'h03, 1'b1, 8'h16, 5'b00001);
    wait_idle();
    issue(4'd7, 8'h81, 8'h00, 1'b1, 8'h81, 5'b01000);
    wait_idle();
    issue(4'd9, 8'h10, 8'h10, 1'b1, 8'h00, 5'b10010);
    wait_idle();
    issue(4'd9, 8'h0F, 8'h03, 1'b1, 8'h2D, 5'b00000);
    wait_idle();
    issue(4'd9, 8'h03, 8'h05, 1'b1, 8'h0F, 5'b00000);
    repeat (2) @(negedge clk);
    issue(4'd0, 8'h40, 8'h40);
    wait_idle();
    issue(4'd0, 8'h02, 8'h02, 1'b1, 8'h04, 5'b00000);
    wait_idle();
    issue(4'd9, 8'h07, 8'h07);
    repeat (2) @(negedge clk);
    do_reset(1'b1);
    issue(4'd0, 8'h02, 8'h03, 1'b1, 8'h05, 5'b00000);
    wait_idle();
    for (int i = 0; i < 300; i++) begin
      int mode;
      mode = $urandom_range(0, 19);
      if (mode == 0) begin
        do_reset(1'($urandom_range(0, 1)));
      end else begin
        if (mode > 4) wait_idle();
        repeat ($urandom_range(0, 2)) @(negedge clk);
        issue(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
      end
    end
    wait_idle();
    repeat (3) @(negedge clk);
    end_req = 1'b1;
  end
endmodule
